// File: rtl/lcd_fifo_pkg.sv
// Shared constants and types for the LCD receive FIFO.
package lcd_fifo_pkg;

  localparam int unsigned DATA_W = 16;

  typedef logic [DATA_W-1:0] entry_t;

  // Pointer width includes one extra wrap bit to tell full from empty.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lcd_fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module lcd_fifo_ram
  import lcd_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lcd_rx_fifo.sv
// First-word-fall-through 16-bit elastic buffer feeding the AHB FIFO read slave.
// Define LCD_RX_FIFO_OUTREG_EN to drive data_out/data_out_vld from a registered output stage.
module lcd_rx_fifo
  import lcd_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          wr_vld,
  input  entry_t                        wr_data,
  output logic                          wr_rdy,
  output entry_t                        data_out,
  output logic                          data_out_vld,
  input  logic                          data_out_rdy,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          push, pop, rd_inc;
  entry_t        rdata;

  // Registered count only: a pop while full does not reopen wr_rdy this cycle.
  assign wr_rdy = rst_n & (count_q < PW'(DEPTH));
  assign push   = wr_vld & wr_rdy;
  assign pop    = data_out_vld & data_out_rdy;
  assign count  = count_q;

  lcd_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

`ifdef LCD_RX_FIFO_OUTREG_EN
  entry_t out_q;
  logic   out_vld_q;
  logic   load;

  // Refill the output stage whenever it is empty or being drained.
  assign load         = (wr_ptr_q != rd_ptr_q) & (~out_vld_q | pop);
  assign rd_inc       = load;
  assign data_out_vld = out_vld_q;
  assign data_out     = out_vld_q ? out_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (clr) begin
      out_vld_q <= 1'b0;
    end else if (load) begin
      out_q     <= rdata;
      out_vld_q <= 1'b1;
    end else if (pop) begin
      out_vld_q <= 1'b0;
    end
  end
`else
  assign rd_inc       = pop;
  assign data_out_vld = (count_q != '0);
  assign data_out     = data_out_vld ? rdata : '0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_inc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + PW'(1);
      end else if (pop && !push) begin
        count_d = count_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_lcd_rx_fifo.sv
// Self-checking bench for lcd_rx_fifo: queue-based reference model plus directed literal checks.
module tb_lcd_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_vld = 1'b0;
  logic [15:0]   wr_data = '0;
  logic          wr_rdy;
  logic [15:0]   data_out;
  logic          data_out_vld;
  logic          data_out_rdy = 1'b0;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  bit done  = 1'b0;

  logic [15:0] model_q [$];

  lcd_rx_fifo #(
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_vld       (wr_vld),
    .wr_data      (wr_data),
    .wr_rdy       (wr_rdy),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .data_out_rdy (data_out_rdy),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: occupancy is a queue, updated from the inputs seen at each edge.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_q.delete();
      end else begin
        bit do_push, do_pop;
        do_push = wr_vld && (model_q.size() < DEPTH);
        do_pop  = data_out_rdy && (model_q.size() > 0);
        if (clr) begin
          model_q.delete();
        end else begin
          if (do_pop) void'(model_q.pop_front());
          if (do_push) model_q.push_back(wr_data);
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check("m_count", int'(count), model_q.size());
        check("m_wr_rdy", int'(wr_rdy), int'(rst_n && (model_q.size() < DEPTH)));
        check("m_vld", int'(data_out_vld), int'(model_q.size() > 0));
        check("m_data", int'(data_out), (model_q.size() > 0) ? int'(model_q[0]) : 0);
      end
    end
  end

  // Apply inputs, let one edge pass, return just after it.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic c);
    wr_vld       = v;
    wr_data      = d;
    data_out_rdy = r;
    clr          = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", int'(count), 0);
    check("rst_vld", int'(data_out_vld), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_wr_rdy", int'(wr_rdy), 0);
    rst_n = 1'b1;
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    check("idle_wr_rdy", int'(wr_rdy), 1);

    cyc(1'b1, 16'hA5A5, 1'b0, 1'b0);
    check("first_vld", int'(data_out_vld), 1);
    check("first_data", int'(data_out), 16'hA5A5);
    check("first_count", int'(count), 1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    check("clr1_count", int'(count), 0);

    for (int i = 0; i < 16; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    check("full_count", int'(count), 16);
    check("full_wr_rdy", int'(wr_rdy), 0);
    cyc(1'b1, 16'h0010, 1'b0, 1'b0);
    check("ovf_count", int'(count), 16);
    check("ovf_head", int'(data_out), 16'h0000);
    cyc(1'b1, 16'h0011, 1'b1, 1'b0);
    check("fullpop_count", int'(count), 15);
    check("fullpop_wr_rdy", int'(wr_rdy), 1);
    check("fullpop_head", int'(data_out), 16'h0001);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);

    cyc(1'b1, 16'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) begin
      check("stream_head", int'(data_out), i - 1);
      cyc(1'b1, 16'(i), 1'b1, 1'b0);
      check("stream_count", int'(count), 1);
    end
    check("stream_last", int'(data_out), 40);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("drain_vld", int'(data_out_vld), 0);

    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 16'h0, 1'b0, 1'b0);
      check("hold_data", int'(data_out), 16'h0100);
    end
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    check("hold_next", int'(data_out), 16'h0101);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);

    for (int i = 0; i < 7; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    check("pre_clr_count", int'(count), 7);
    cyc(1'b1, 16'h02FF, 1'b1, 1'b1);
    check("clr_count", int'(count), 0);
    check("clr_vld", int'(data_out_vld), 0);

    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b0);
    wr_vld = 1'b1;
    rst_n  = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_vld", int'(data_out_vld), 0);
    check("arst_data", int'(data_out), 0);
    check("arst_wr_rdy", int'(wr_rdy), 0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc(1'b1, 16'h0BEE, 1'b0, 1'b0);
    check("post_rst_data", int'(data_out), 16'h0BEE);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
